// File: rtl/lisp_pkg.sv
// rtl/lisp_pkg.sv - tagged Lisp cell constants and cell-fetch helpers
package lisp;

  localparam int TAG_W          = 8;
  localparam int CELL_MAX_WORDS = 4;

  localparam logic [TAG_W-1:0] NIL            = 8'h00;
  localparam logic [TAG_W-1:0] TYPE_NUMBER    = 8'h01;
  localparam logic [TAG_W-1:0] TYPE_CONS      = 8'h02;
  localparam logic [TAG_W-1:0] TYPE_FUNC_PRIM = 8'h03;
  localparam logic [TAG_W-1:0] TYPE_PRIM_CONS = 8'h10;
  localparam logic [TAG_W-1:0] TYPE_PRIM_CAR  = 8'h11;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} fetch_state_t;

  function automatic logic tag_known(input logic [TAG_W-1:0] tag);
    return (tag == NIL) || (tag == TYPE_NUMBER) ||
           (tag == TYPE_CONS) || (tag == TYPE_FUNC_PRIM);
  endfunction

  // Unknown tags report a single-word cell so the fetch terminates right after the tag.
  function automatic logic [2:0] cell_len(input logic [TAG_W-1:0] tag);
    case (tag)
      NIL:            return 3'd1;
      TYPE_NUMBER:    return 3'd2;
      TYPE_CONS:      return 3'd3;
      TYPE_FUNC_PRIM: return 3'd4;
      default:        return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/rom_cell_fetcher_len_decode.sv
// rtl/rom_cell_fetcher_len_decode.sv - combinational tag to cell length / error decode
module cell_len_decode
  import lisp::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_tag,
  output logic [2:0]            o_len,
  output logic                  o_err
);

  logic [TAG_W-1:0] w_tag_lo;
  logic             w_hi_zero;

  assign w_tag_lo  = TAG_W'(i_tag);
  // Words wider than a tag must carry zero upper bits to be a valid tag.
  assign w_hi_zero = ((i_tag >> TAG_W) == '0);
  assign o_err     = !(w_hi_zero && tag_known(w_tag_lo));
  assign o_len     = o_err ? 3'd1 : cell_len(w_tag_lo);

endmodule

// File: rtl/rom_cell_fetcher.sv
// rtl/rom_cell_fetcher.sv - sequences multi-word reads of one tagged cell from the heap ROM
module rom_cell_fetcher
  import lisp::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_tag,
  output logic [DATA_WIDTH-1:0] rsp_f0,
  output logic [DATA_WIDTH-1:0] rsp_f1,
  output logic [DATA_WIDTH-1:0] rsp_f2,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  fetch_state_t          r_state;
  fetch_state_t          w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [2:0]            r_idx;
  logic [2:0]            r_len;
  logic [DATA_WIDTH-1:0] r_tag;
  logic [DATA_WIDTH-1:0] r_f0;
  logic [DATA_WIDTH-1:0] r_f1;
  logic [DATA_WIDTH-1:0] r_f2;
  logic                  r_err;
  logic [2:0]            w_len;
  logic                  w_err;
  logic                  w_last;

  cell_len_decode #(.DATA_WIDTH(DATA_WIDTH)) u_len_decode (
    .i_tag (rom_data),
    .o_len (w_len),
    .o_err (w_err)
  );

  // During the tag cycle r_len is not yet valid, so use the live decode.
  assign w_last = (r_idx == 3'd1) ? (w_len == 3'd1) : (r_idx == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rom_addr  = r_base + ADDR_WIDTH'(r_idx);
    case (r_state)
      IDLE: begin
        req_ready = !rst;
        rom_addr  = req_addr;
        if (req_valid) w_next = FETCH;
      end
      FETCH: begin
        if (w_last) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_idx  <= '0;
      r_len  <= '0;
      r_tag  <= '0;
      r_f0   <= '0;
      r_f1   <= '0;
      r_f2   <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_base <= req_addr;
            r_idx  <= 3'd1;
          end
        end
        FETCH: begin
          r_idx <= r_idx + 3'd1;
          // rom_data holds word idx-1; clearing fields on the tag keeps unused slots at zero.
          case (r_idx)
            3'd1: begin
              r_tag <= rom_data;
              r_len <= w_len;
              r_err <= w_err;
              r_f0  <= '0;
              r_f1  <= '0;
              r_f2  <= '0;
            end
            3'd2:    r_f0 <= rom_data;
            3'd3:    r_f1 <= rom_data;
            3'd4:    r_f2 <= rom_data;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign rsp_tag = r_tag;
  assign rsp_f0  = r_f0;
  assign rsp_f1  = r_f1;
  assign rsp_f2  = r_f2;
  assign rsp_err = r_err;

endmodule

// File: doc/rom_cell_fetcher.md
Name: rom_cell_fetcher

Overview:
- Sequences multi-word reads of one tagged Lisp cell from the synchronous heap ROM, which has 1-cycle read latency.
- Accepts a cell base address over a valid/ready request channel.
- Reads the tag word, decodes the cell length from the tag, and streams the remaining field words.
- Presents the assembled cell on a valid/ready response channel; sits between the evaluator and the ROM as the ROM's sole address driver.

Parameters:
- ADDR_WIDTH, 8, ROM address width; cell base and field addresses.
- DATA_WIDTH, 8, ROM word width; tag and field width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  fetcher can accept request
- req_addr  in  ADDR_WIDTH  cell base address
- rsp_valid  out  1  assembled cell available
- rsp_ready  in  1  consumer takes cell
- rsp_tag  out  DATA_WIDTH  word at base
- rsp_f0  out  DATA_WIDTH  word at base+1 (NUMBER value / CONS car / PRIM id), else 0
- rsp_f1  out  DATA_WIDTH  word at base+2 (CONS cdr / PRIM reserved), else 0
- rsp_f2  out  DATA_WIDTH  word at base+3 (PRIM reserved), else 0
- rsp_err  out  1  tag not recognised
- rom_addr  out  ADDR_WIDTH  to ROM addr
- rom_data  in  DATA_WIDTH  from ROM data_out

Behaviour:
- One clock (clk); reset asynchronous, active-high (rst).
- Reset values:
  - state=IDLE; rsp_valid=0; rsp_tag/f0/f1/f2=0; rsp_err=0.
  - req_ready=1 once rst deasserts.
  - Internal base/idx/len=0.
- States: IDLE, FETCH, RESP.
- IDLE:
  - req_ready=1; rom_addr = req_addr (combinational), so the ROM samples the tag address on the accept edge.
  - Accept at edge T when req_valid&&req_ready: latch base, idx<=1, go FETCH.
- FETCH:
  - req_ready=0; rom_addr = base+idx (mod 2^ADDR_WIDTH, silent wrap).
  - Each cycle, rom_data holds word idx-1; store it into its slot, then idx<=idx+1.
  - The first FETCH cycle delivers the tag. Length is decoded combinationally from it and registered:
    - NIL: 1 word
    - TYPE_NUMBER: 2 words
    - TYPE_CONS: 3 words
    - TYPE_FUNC_PRIM: 4 words
    - any other tag: 1 word, err=1
  - After storing word len-1, go RESP. One word beyond the cell may be issued to the ROM; this is harmless and must not alter outputs.
- Latency from accept edge to rsp_valid high: NIL/err 2 cycles, NUMBER 3, CONS 4, PRIM 5.
- Unused field slots are 0 in the response, never stale.
- RESP:
  - rsp_valid=1; outputs stable until rsp_valid&&rsp_ready, then IDLE.
  - req_ready stays 0 in RESP: no overlap, no response bypass.
  - Earliest next accept is the cycle after the handshake.
- Exactly one response per accepted request.
- rsp_ready is ignored outside RESP; req_valid is ignored outside IDLE.
- rst asserted mid-FETCH or mid-RESP: immediate return to IDLE, rsp_valid=0, in-flight request dropped with no response.

Decomposition:
- Package lisp supplies the tag constants NIL, TYPE_NUMBER, TYPE_CONS, TYPE_FUNC_PRIM, TYPE_PRIM_CONS and TYPE_PRIM_CAR.
- Add to lisp:
  - cell_len function (tag -> word count, 1..4);
  - fetch_state_t enum {IDLE, FETCH, RESP};
  - CELL_MAX_WORDS=4.
- Sub-module cell_len_decode (combinational tag -> len, err) is natural and reusable by the printer.
- The ROM module is instantiated only in the testbench/top, not inside this block.

Test Plan:
- Heap image [0]=NIL, [1]=TYPE_NUMBER, [2]=0x12, req_addr=0x01, rsp_ready=1 -> rsp_valid 3 cycles after accept; tag=TYPE_NUMBER, f0=0x12, f1=f2=0, err=0.
- [9]=TYPE_CONS, [A]=0x02, [B]=NIL, req 0x09 -> 4-cycle latency; tag=TYPE_CONS, f0=0x02, f1=NIL, f2=0.
- [5]=TYPE_FUNC_PRIM, [6]=TYPE_PRIM_CONS, req 0x05, rsp_ready low 6 cycles -> 5-cycle latency; outputs held stable; req_ready=0 throughout; one handshake then IDLE.
- req 0x00 (NIL), then word 0x7F (unknown tag) at 0x20 -> NIL cell in 2 cycles, err=0; 0x20 cell in 2 cycles, err=1, f0..f2=0.
- Back-to-back: req_valid held high with addresses 0x01 then 0x09 -> second accept only after first handshake; responses in order.
- rst pulsed 2 cycles after accepting a CONS fetch -> rsp_valid never rises; req_ready=1 after release; new request 0x01 returns 0x12 correctly.
- Cell at 0xFE with ADDR_WIDTH=8 -> field address wraps to 0x00.
